// File: rtl/timing_control_pkg.sv
// Shared constants for the control-unit timing generator.
//   SC_W / NT      : sequence-counter width and number of one-hot timing signals
//   PH_*           : instruction-phase encodings driven on the phase output
//   T_*            : named timing-signal indices
//   SC_INTR_LAST   : last count of the three-cycle interrupt cycle
//   SC_IRQ_MIN     : earliest count at which a pending interrupt is accepted
package timing_control_pkg;

    localparam int unsigned SC_W = 4;
    localparam int unsigned NT   = 16;

    localparam logic [1:0] PH_FETCH  = 2'd0;
    localparam logic [1:0] PH_DECODE = 2'd1;
    localparam logic [1:0] PH_EXEC   = 2'd2;
    localparam logic [1:0] PH_INTR   = 2'd3;

    localparam int unsigned T_FETCH0 = 0;
    localparam int unsigned T_FETCH1 = 1;
    localparam int unsigned T_DECODE = 2;

    localparam logic [SC_W-1:0] SC_INTR_LAST = SC_W'(2);
    localparam logic [SC_W-1:0] SC_IRQ_MIN   = SC_W'(3);
    localparam logic [NT-1:0]   T_RESET      = NT'(1);

endpackage

// File: rtl/sc_onehot_decoder.sv
// Combinational binary-to-one-hot decoder for the sequence counter.
//   sc : binary count (W bits)
//   t  : one-hot vector (N bits), t[sc] = 1
module sc_onehot_decoder #(
    parameter int unsigned W = 4,
    parameter int unsigned N = 16
) (
    input  logic [W-1:0] sc,
    output logic [N-1:0] t
);

    always_comb begin
        t     = '0;
        t[sc] = 1'b1;
    end

endmodule

// File: rtl/timing_control.sv
// Sequence counter and timing-signal generator for the basic-computer control unit.
// Owns SC, registers the one-hot timing vector alongside it, tracks the interrupt
// cycle flag R and a sticky wrap-error flag.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   en          : run enable; 0 freezes all state
//   clr_sc      : end-of-instruction request, returns SC to 0
//   ien         : interrupt enable flip-flop
//   irq_pend    : OR of pending I/O flags
//   sc, t       : current count and its registered one-hot decode
//   phase       : FETCH / DECODE / EXECUTE / INTR
//   r           : interrupt-cycle flag
//   decode_stb  : T2 outside the interrupt cycle
//   intr_ack    : T2 inside the interrupt cycle
//   err_wrap    : sticky, SC wrapped 15->0 without clr_sc
module timing_control
    import timing_control_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clr_sc,
    input  logic            ien,
    input  logic            irq_pend,
    output logic [SC_W-1:0] sc,
    output logic [NT-1:0]   t,
    output logic [1:0]      phase,
    output logic            r,
    output logic            decode_stb,
    output logic            intr_ack,
    output logic            err_wrap
);

    logic [SC_W-1:0] sc_q, sc_d, sc_inc;
    logic [NT-1:0]   t_q, t_d;
    logic            r_q, r_d;
    logic            err_q, err_d;
    logic            in_intr_cycle;

    assign sc_inc = sc_q + SC_W'(1);

    // R set mid-instruction only takes over SC once the count is back at 0..2.
    assign in_intr_cycle = r_q && (sc_q <= SC_INTR_LAST);

    always_comb begin
        sc_d  = sc_q;
        r_d   = r_q;
        err_d = err_q;
        if (in_intr_cycle) begin
            // Fixed three-cycle sequence; clr_sc has no effect here.
            if (sc_q == SC_INTR_LAST) begin
                sc_d = '0;
                r_d  = 1'b0;
            end else begin
                sc_d = sc_inc;
            end
        end else begin
            if (clr_sc) begin
                sc_d = '0;
            end else begin
                sc_d = sc_inc;
                if (sc_q == '1) begin
                    err_d = 1'b1;
                end
            end
            if (!r_q && (sc_q >= SC_IRQ_MIN) && ien && irq_pend) begin
                r_d = 1'b1;
            end
        end
    end

    // Next T is decoded from next SC so both registers always agree.
    sc_onehot_decoder #(
        .W(SC_W),
        .N(NT)
    ) u_dec (
        .sc(sc_d),
        .t (t_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q  <= '0;
            t_q   <= T_RESET;
            r_q   <= 1'b0;
            err_q <= 1'b0;
        end else if (en) begin
            sc_q  <= sc_d;
            t_q   <= t_d;
            r_q   <= r_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        if (in_intr_cycle) begin
            phase = PH_INTR;
        end else if (t_q[T_FETCH0] || t_q[T_FETCH1]) begin
            phase = PH_FETCH;
        end else if (t_q[T_DECODE]) begin
            phase = PH_DECODE;
        end else begin
            phase = PH_EXEC;
        end
    end

    assign sc         = sc_q;
    assign t          = t_q;
    assign r          = r_q;
    assign err_wrap   = err_q;
    assign decode_stb = t_q[T_DECODE] & ~r_q;
    assign intr_ack   = t_q[T_DECODE] & r_q;

endmodule

// File: tb/tb_timing_control.sv
// Scoreboard bench for timing_control: stimulus pushes hand-computed expected
// state after each clock edge (or asynchronous reset); a monitor pops and compares.
module tb_timing_control;

  localparam logic [1:0] PF = 2'd0;
  localparam logic [1:0] PD = 2'd1;
  localparam logic [1:0] PE = 2'd2;
  localparam logic [1:0] PI = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        en, clr_sc, ien, irq_pend;
  logic [3:0]  sc;
  logic [15:0] t;
  logic [1:0]  phase;
  logic        r, decode_stb, intr_ack, err_wrap;

  typedef struct {
    logic [3:0]  sc;
    logic [15:0] t;
    logic [1:0]  ph;
    logic        r;
    logic        dstb;
    logic        iack;
    logic        err;
    string       name;
  } exp_t;

  exp_t queue_exp[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  timing_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr_sc    (clr_sc),
    .ien       (ien),
    .irq_pend  (irq_pend),
    .sc        (sc),
    .t         (t),
    .phase     (phase),
    .r         (r),
    .decode_stb(decode_stb),
    .intr_ack  (intr_ack),
    .err_wrap  (err_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  function automatic logic [1:0] ph_norm(input int s);
    if (s <= 1) return PF;
    if (s == 2) return PD;
    return PE;
  endfunction

  function automatic exp_t mk(input int esc, input logic er, input logic [1:0] eph,
                              input logic eerr, input string nm);
    exp_t x;
    logic [15:0] one;
    one    = 16'h0001;
    x.sc   = esc[3:0];
    x.t    = one << esc;
    x.ph   = eph;
    x.r    = er;
    x.dstb = (esc == 2) && !er;
    x.iack = (esc == 2) && er;
    x.err  = eerr;
    x.name = nm;
    return x;
  endfunction

  task automatic step(input logic e, input logic c, input logic ie, input logic ip,
                      input int esc, input logic er, input logic [1:0] eph,
                      input logic eerr, input string nm);
    en       = e;
    clr_sc   = c;
    ien      = ie;
    irq_pend = ip;
    @(posedge clk);
    #1;
    queue_exp.push_back(mk(esc, er, eph, eerr, nm));
  endtask

  task automatic expect_now(input string nm);
    queue_exp.push_back(mk(0, 1'b0, PF, 1'b0, nm));
    -> sample_ev;
  endtask

  // Async reset in the low half of the clock, checked before any edge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 expect_now(nm);
    #1 rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      while (queue_exp.size() > 0) begin
        exp_t x;
        x = queue_exp.pop_front();
        checks++;
        if (sc !== x.sc || t !== x.t || phase !== x.ph || r !== x.r ||
            decode_stb !== x.dstb || intr_ack !== x.iack || err_wrap !== x.err) begin
          errors++;
          $display("FAIL %s: got sc=%0d t=%h ph=%0d r=%b dstb=%b iack=%b err=%b; want sc=%0d t=%h ph=%0d r=%b dstb=%b iack=%b err=%b",
                   x.name, sc, t, phase, r, decode_stb, intr_ack, err_wrap,
                   x.sc, x.t, x.ph, x.r, x.dstb, x.iack, x.err);
        end
      end
    end
  end

  // Invariants: T tracks onehot(SC) and is always exactly one-hot
  always @(negedge clk) begin
    checks++;
    if (t !== (16'h0001 << sc)) begin
      errors++;
      $display("FAIL invariant: t=%h does not match onehot(sc=%0d)", t, sc);
    end
    if ($countones(t) != 1) begin
      errors++;
      $display("FAIL invariant: t=%h is not one-hot", t);
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; en = 1'b0; clr_sc = 1'b0; ien = 1'b0; irq_pend = 1'b0;
    #12 expect_now("reset");
    #1 rst_n = 1'b1;

    // Basic count and DECODE strobe
    step(1, 0, 0, 0, 1, 0, PF, 0, "cnt1");
    step(1, 0, 0, 0, 2, 0, PD, 0, "cnt2");
    step(1, 0, 0, 0, 3, 0, PE, 0, "cnt3");
    step(1, 0, 0, 0, 4, 0, PE, 0, "cnt4");
    step(1, 0, 0, 0, 5, 0, PE, 0, "cnt5");
    step(1, 1, 0, 0, 0, 0, PF, 0, "clr_at5");

    // Wrap without clear sets the sticky error
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 0, i % 16, 0, ph_norm(i % 16), (i == 16), "wrap");
    end
    step(1, 1, 0, 0, 0, 0, PF, 1, "err_sticky_clr");
    step(1, 0, 0, 0, 1, 0, PF, 1, "err_sticky_cnt");
    do_reset("err_cleared_by_reset");

    // Clear at 15 is not a wrap
    for (int i = 1; i <= 15; i++) begin
      step(1, 0, 0, 0, i, 0, ph_norm(i), 0, "to15");
    end
    step(1, 1, 0, 0, 0, 0, PF, 0, "clr_at15");

    // Interrupt: pending from SC=1, accepted at SC=3
    step(1, 0, 0, 0, 1, 0, PF, 0, "pre_irq");
    step(1, 0, 1, 1, 2, 0, PD, 0, "irq_at_sc1");
    step(1, 0, 1, 1, 3, 0, PE, 0, "irq_at_sc2");
    step(1, 0, 1, 1, 4, 1, PE, 0, "irq_taken");
    step(1, 1, 1, 0, 0, 1, PI, 0, "intr_sc0");
    step(1, 1, 0, 0, 1, 1, PI, 0, "intr_clr_ignored");
    step(1, 0, 0, 0, 2, 1, PI, 0, "intr_ack");
    step(1, 0, 0, 0, 0, 0, PF, 0, "intr_exit");
    step(1, 0, 0, 0, 1, 0, PF, 0, "post_intr");

    // EN=0 freezes state even with clr_sc held
    for (int i = 2; i <= 6; i++) begin
      step(1, 0, 0, 0, i, 0, ph_norm(i), 0, "to6");
    end
    repeat (5) step(0, 1, 0, 0, 6, 0, PE, 0, "frozen");
    step(1, 1, 0, 0, 0, 0, PF, 0, "unfreeze_clr");

    // Async reset during the interrupt cycle
    step(1, 0, 0, 0, 1, 0, PF, 0, "r2_1");
    step(1, 0, 0, 0, 2, 0, PD, 0, "r2_2");
    step(1, 0, 0, 0, 3, 0, PE, 0, "r2_3");
    step(1, 0, 1, 1, 4, 1, PE, 0, "r2_taken");
    step(1, 1, 0, 0, 0, 1, PI, 0, "r2_intr0");
    step(1, 0, 0, 0, 1, 1, PI, 0, "r2_intr1");
    do_reset("rst_mid_intr");
    step(1, 0, 0, 0, 1, 0, PF, 0, "post_rst");

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    if (errors != 0 || checks < 12) begin
      $display("FAIL");
      $fatal(1);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule

// File: doc/timing_control.md
Name: timing_control

Overview:
- Consumer side of the 4-bit sequence counter interface in the basic-computer control unit.
- Owns the SC register plus its clear/step control.
- Produces registered one-hot timing signals T0..T15 and the instruction-phase indication (fetch/decode/execute/interrupt).
- Runs the fixed 3-cycle interrupt cycle.
- Sits between the instruction decoder/execute logic (which request SC clear) and the datapath control-word generation (which consumes T and phase).

Parameters:
- SC_W, 4, width of the sequence counter.
- NT, 16, number of timing signals; must equal 2**SC_W.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  run enable (start/stop flip-flop S); 0 freezes all state.
- CLR_SC  input  1  end-of-instruction request from execute logic; returns SC to 0.
- IEN  input  1  interrupt enable flip-flop value.
- IRQ_PEND  input  1  OR of pending I/O flags (FGI|FGO).
- SC  output  SC_W  current sequence count.
- T  output  NT  one-hot timing vector; T[SC] high.
- PHASE  output  2  0=FETCH, 1=DECODE, 2=EXECUTE, 3=INTR.
- R  output  1  interrupt-cycle flag.
- DECODE_STB  output  1  high for the single cycle T2 & ~R.
- INTR_ACK  output  1  high during R & T2; datapath clears IEN and loads the vector.
- ERR_WRAP  output  1  sticky: SC wrapped 15->0 without CLR_SC.

Behaviour:
- Reset (RST_N low, async): SC=0, T=16'h0001, R=0, ERR_WRAP=0. Consequently PHASE=FETCH, DECODE_STB=0, INTR_ACK=0. Holds until RST_N rises; first update on the next CLK edge.
- All state updates on the rising CLK edge, and only when EN=1. With EN=0, SC, T, R and ERR_WRAP hold.
- T is a register updated together with SC, so T equals onehot(SC) every cycle with no lag. T is never zero and never multi-hot.
- SC update when EN=1 and R=0:
  - CLR_SC=1: SC<=0.
  - Otherwise: SC<=SC+1, modulo 2**SC_W.
- Wrap: if the increment takes SC from 15 to 0 with CLR_SC=0, ERR_WRAP<=1 (sticky until reset) and counting continues. CLR_SC at SC=15 clears SC with no error.
- Interrupt entry: at an edge with EN=1, R=0, SC>=3, IEN=1 and IRQ_PEND=1, R<=1.
  - The same edge still applies the normal SC rule (clear if CLR_SC, else increment).
  - The interrupt cycle begins once SC reaches 0.
  - IRQ_PEND while SC is 0..2 is not taken until SC>=3.
- Interrupt cycle (R=1), exactly three cycles:
  - SC steps 0->1->2, ignoring CLR_SC.
  - At the edge leaving SC=2: SC<=0 and R<=0.
  - R=1 at SC>=3 (entry mid-instruction) holds R; SC continues the normal rule until cleared.
- PHASE decode (combinational from R, SC):
  - R=1 and SC<=2: INTR.
  - Otherwise SC<=1: FETCH.
  - Otherwise SC==2: DECODE.
  - Otherwise: EXECUTE.
- DECODE_STB = T[2] & ~R. INTR_ACK = T[2] & R. Both are combinational from registers, so glitch-free relative to CLK.
- Reset asserted mid-instruction or mid-interrupt-cycle: immediate return to reset values; no pending interrupt is retained.

Decomposition:
- Shared package/include: SC_W and NT constants; PHASE encodings PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_INTR=3; named timing indices T_FETCH0=0, T_FETCH1=1, T_DECODE=2.
- One sub-module: sc_onehot_decoder (combinational SC_W-to-NT one-hot), used to compute the next T value registered alongside SC.

Test Plan:
- Reset then EN=1, CLR_SC=0 -> SC=0,1,2,3...; T=0001,0002,0004,0008 (hex); PHASE=F,F,D,E; DECODE_STB high only at SC=2.
- CLR_SC pulsed at SC=5 -> next cycle SC=0, T=0001, PHASE=FETCH, ERR_WRAP=0.
- No CLR_SC for 16 edges -> SC returns to 0 and ERR_WRAP=1; stays 1 after a later CLR_SC; cleared only by RST_N=0.
- IEN=1, IRQ_PEND=1 asserted at SC=1 -> R stays 0 until the edge at SC=3 sets R=1; CLR_SC at SC=4 -> SC=0 with PHASE=INTR for three cycles; INTR_ACK high at SC=2; then R=0, SC=0, PHASE=FETCH.
- EN=0 at SC=6 for 5 cycles with CLR_SC=1 -> SC=6, T=0040 unchanged; after EN=1 the CLR_SC takes effect on the next edge.
- RST_N dropped asynchronously mid-cycle while R=1, SC=1 -> outputs reset immediately (SC=0, T=0001, R=0) without waiting for CLK.
